sprite_palette_unit: RTL
========================

Name: sprite_palette_unit

Overview:
- Runtime-writable, multi-bank colour palette for sprite rendering. Maps a sprite pixel index plus bank select to 12-bit RGB through a 2-stage registered pipeline.
- Adds a transparency flag and a frame-timed hit-flash effect.
- Sits between the sprite ROM/address generator and the VGA colour mux. One instance serves one fighter; the bank selects the costume or animation set.

Parameters:
- IDX_W, 4, pixel index width; entries per bank = 2**IDX_W
- BANKS, 4, number of palette banks (power of two, >=1)
- CH_W, 4, bits per colour channel
- TRANSPARENT_IDX, 0, index reported as transparent (colour-key)
- FLASH_TICKS, 8, frame ticks per hit flash (>=1)

Ports:
- Clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pix_valid  in  1  lookup request this cycle
- pix_index  in  IDX_W  palette index
- pix_bank  in  $clog2(BANKS) (min 1)  bank select
- rgb_valid  out  1  output pixel valid
- red, green, blue  out  CH_W each  colour
- transparent  out  1  pixel equals colour-key
- wr_en  in  1  palette write strobe
- wr_bank  in  $clog2(BANKS)  write bank
- wr_index  in  IDX_W  write entry
- wr_rgb  in  3*CH_W  {r,g,b} write data
- frame_tick  in  1  one-cycle pulse per video frame
- flash_start  in  1  one-cycle hit-flash request
- flash_busy  out  1  flash in progress

Behaviour:
- Reset (async, reset_n=0): every bank is loaded with DEFAULT_PALETTE. Clears rgb_valid, red, green, blue, transparent, flash_busy, pipeline valids, flash counter and phase.
- Storage: BANKS x 2**IDX_W x 3*CH_W register array.
- Write: on a Clk edge with wr_en=1, entry [wr_bank][wr_index] <= wr_rgb. Writes are unconditional; there is no stall.
- Pipeline, latency 2:
  - Stage 1 registers pix_valid, pix_index, pix_bank.
  - Stage 2 reads the array with the stage-1 address and registers the outputs.
  - A request accepted at cycle t appears at t+2, with one result per cycle and no bubbles.
- Write ordering: a lookup issued at cycle t sees every write issued at cycles <= t, and sees no write issued at t+1 or later. A write in the same cycle as the lookup is therefore visible.
- When stage-2 valid=0: rgb_valid=0; red, green, blue and transparent hold their previous values.
- transparent = (stage-1 index == TRANSPARENT_IDX), for any bank. The RGB output is still the stored entry.
- Flash FSM, states IDLE and FLASH:
  - IDLE + flash_start: go to FLASH; cnt <= FLASH_TICKS; phase <= 1.
  - FLASH + frame_tick: cnt <= cnt-1; phase toggles. If cnt==1, go to IDLE and clear phase.
  - FLASH + flash_start: restart with cnt=FLASH_TICKS and phase=1.
  - flash_start and frame_tick in the same cycle: start wins and the tick is ignored.
  - flash_busy = (state==FLASH), registered.
- Flash output: when phase=1 at the stage-2 load and the pixel is not transparent, the outputs are all-ones (white). Transparent pixels are never flashed.
- Reset mid-flash or mid-pipeline: everything clears immediately. Palette contents revert to DEFAULT_PALETTE.
- Widths: no arithmetic on colour. The counter width is $clog2(FLASH_TICKS+1).

Decomposition:
- Package sprite_palette_pkg:
  - rgb_t struct {r,g,b} of CH_W.
  - DEFAULT_PALETTE (16 x 12-bit) with entry 0 = F0F, 1 = 002, 2 = 666, 7 = C0C, 10 = 000, 11 = 888. Entries beyond 16 are replicated modulo 16.
  - flash_state_e {IDLE, FLASH}.
- One sub-module, palette_flash_ctrl: the FSM, counter and phase, with outputs phase and flash_busy.
- The palette array and pipeline live in the top module.

Test Plan:
- Reset, then pix_valid with index 2, bank 0 at cycle t -> at t+2: rgb_valid=1, {r,g,b}=6,6,6, transparent=0. Before t+2: rgb_valid=0.
- Back-to-back requests with indices 0, 1, 11 on consecutive cycles -> three consecutive outputs F0F (transparent=1), 002, 888, no gaps.
- Write bank 2 index 5 = 3A7 in the same cycle as a lookup of bank 2 index 5 -> result 3A7. Bank 0 index 5 is unchanged.
- Write 123 at t+1 after a lookup of the same entry at t -> the lookup returns the old value. The next lookup returns 123.
- FLASH_TICKS=2 flash, checked on each frame_tick:
  - After flash_start: flash_busy=1 and opaque index 1 outputs FFF.
  - After 1 tick: outputs 002.
  - After 2 ticks: flash_busy=0 and output stays 002.
  - Index 0 stays F0F with transparent=1 throughout.
- Mid-flash checks:
  - flash_start coincident with frame_tick -> cnt=FLASH_TICKS and phase=1.
  - reset_n low mid-flash with a written palette -> flash_busy=0, rgb_valid=0, and bank 2 index 5 reads back the default value.

Source files
------------

// File: rtl/sprite_palette_pkg.sv
// Shared types and the power-on colour table for the sprite palette unit.
// The table is authored at 4 bits per channel; the top widens or narrows it to CH_W.
package sprite_palette_pkg;

  localparam int PAL_CH_W    = 4;
  localparam int PAL_ENTRIES = 16;

  typedef struct packed {
    logic [PAL_CH_W-1:0] r;
    logic [PAL_CH_W-1:0] g;
    logic [PAL_CH_W-1:0] b;
  } rgb_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_e;

  localparam logic [3*PAL_CH_W-1:0] DEFAULT_PALETTE [PAL_ENTRIES] = '{
    12'hF0F, 12'h002, 12'h666, 12'hFDB,
    12'hC84, 12'h04C, 12'h08F, 12'hC0C,
    12'hF00, 12'hFF0, 12'h000, 12'h888,
    12'h0F0, 12'hAAA, 12'hFFF, 12'hF80
  };

  // Banks larger than the table simply repeat it.
  function automatic rgb_t default_color(input int unsigned idx);
    logic [3:0] sel;
    sel = 4'(idx % PAL_ENTRIES);
    return rgb_t'(DEFAULT_PALETTE[sel]);
  endfunction

endpackage

// File: rtl/palette_flash_ctrl.sv
// Hit-flash sequencer: counts frame ticks and produces the white/normal phase
// that the palette pipeline uses to override opaque pixels.
module palette_flash_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int FLASH_TICKS = 8,
  localparam int CNT_W = $clog2(FLASH_TICKS + 1)
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic frame_tick,
  input  logic flash_start,
  output logic phase,
  output logic flash_busy
);

  flash_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // A new hit always restarts the flash, even on a frame boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (flash_start) begin
      state_d = FLASH;
      cnt_d   = CNT_W'(FLASH_TICKS);
      phase_d = 1'b1;
    end else if (state_q == FLASH && frame_tick) begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        phase_d = 1'b0;
      end else begin
        cnt_d   = cnt_q - CNT_W'(1);
        phase_d = ~phase_q;
      end
    end
  end

  assign phase      = phase_q;
  assign flash_busy = (state_q == FLASH);

endmodule

// File: rtl/sprite_palette_unit.sv
// Multi-bank runtime-writable sprite palette with a two-stage lookup pipeline,
// colour-key transparency and a frame-timed hit flash.
module sprite_palette_unit
  import sprite_palette_pkg::*;
#(
  parameter int IDX_W           = 4,
  parameter int BANKS           = 4,
  parameter int CH_W            = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int FLASH_TICKS     = 8,
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              pix_valid,
  input  logic [IDX_W-1:0]  pix_index,
  input  logic [BANK_W-1:0] pix_bank,
  output logic              rgb_valid,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transparent,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              frame_tick,
  input  logic              flash_start,
  output logic              flash_busy
);

  localparam int ENTRIES = 2 ** IDX_W;

  function automatic logic [CH_W-1:0] to_ch(input logic [PAL_CH_W-1:0] nib);
    logic [CH_W-1:0] o;
    o = '0;
    for (int i = 0; i < CH_W; i++) begin
      o[CH_W-1-i] = nib[PAL_CH_W-1-(i % PAL_CH_W)];
    end
    return o;
  endfunction

  function automatic logic [3*CH_W-1:0] default_word(input int unsigned e);
    rgb_t c;
    c = default_color(e);
    return {to_ch(c.r), to_ch(c.g), to_ch(c.b)};
  endfunction

  function automatic logic [BANK_W-1:0] bank_sel(input logic [BANK_W-1:0] b);
    return (BANKS == 1) ? '0 : b;
  endfunction

  logic [3*CH_W-1:0] pal [BANKS][ENTRIES];

  logic              s1_valid;
  logic [IDX_W-1:0]  s1_index;
  logic [BANK_W-1:0] s1_bank;
  logic [3*CH_W-1:0] rd_word;
  logic              s1_transparent;
  logic              phase;

  // Writes land on the same edge that captures a lookup address, so a
  // same-cycle write is already in the array when stage 2 reads it.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < BANKS; b++) begin
        for (int e = 0; e < ENTRIES; e++) begin
          pal[b][e] <= default_word(e);
        end
      end
    end else if (wr_en) begin
      pal[bank_sel(wr_bank)][wr_index] <= wr_rgb;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_index <= '0;
      s1_bank  <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_index <= pix_index;
      s1_bank  <= pix_bank;
    end
  end

  assign rd_word        = pal[bank_sel(s1_bank)][s1_index];
  assign s1_transparent = (s1_index == IDX_W'(TRANSPARENT_IDX));

  // Colour outputs only move on a valid pixel so the mux downstream sees a stable value.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_valid   <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      transparent <= 1'b0;
    end else begin
      rgb_valid <= s1_valid;
      if (s1_valid) begin
        transparent <= s1_transparent;
        if (phase && !s1_transparent) begin
          {red, green, blue} <= '1;
        end else begin
          {red, green, blue} <= rd_word;
        end
      end
    end
  end

  palette_flash_ctrl #(
    .FLASH_TICKS(FLASH_TICKS)
  ) u_flash (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .flash_start(flash_start),
    .phase      (phase),
    .flash_busy (flash_busy)
  );

endmodule
